// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP weight path: field widths, address layout,
// fetch sequencer state encoding and the skid-buffer beat format.
package mlp_pkg;

  localparam int LAYER_W    = 2;
  localparam int NEURON_W   = 4;
  localparam int INDEX_W    = 10;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;

  // Bit offsets of the fields inside a weight memory address
  localparam int LAYER_LSB  = 14;
  localparam int NEURON_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // One weight travelling to the MAC together with its position in the fan-in
  typedef struct packed {
    logic [DATA_W-1:0]  weight;
    logic [INDEX_W-1:0] index;
    logic               last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  // Assemble {layer, neuron, index}; the index field is exactly INDEX_W bits
  // wide so it can never carry into the neuron field.
  function automatic logic [ADDR_W-1:0] make_addr(
    input logic [LAYER_W-1:0]  layer_f,
    input logic [NEURON_W-1:0] neuron_f,
    input logic [INDEX_W-1:0]  index_f
  );
    return {layer_f, neuron_f, index_f};
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Small circular skid buffer holding weight beats between the memory read
// port and the MAC handshake. Push while full is accepted only when a pop
// happens in the same cycle; push and pop together leave the count unchanged.
module weight_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 19,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty_o = (count_q == CNT_W'(0));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify requests against occupancy and work out the next count
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/weight_fetch.sv
// Weight memory read sequencer: walks the fan-in addresses of one neuron,
// absorbs the one-cycle memory latency and streams signed weights to the MAC
// through a valid/ready skid buffer.
module weight_fetch
  import mlp_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LAYER_W-1:0]  layer,
  input  logic [NEURON_W-1:0] neuron,
  input  logic [INDEX_W:0]    num_inputs,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_weight,
  output logic [INDEX_W-1:0]  out_index,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [INDEX_W:0] CNT_ONE = {{INDEX_W{1'b0}}, 1'b1};

  fetch_state_e        state_q;
  logic [LAYER_W-1:0]  layer_q;
  logic [NEURON_W-1:0] neuron_q;
  logic [INDEX_W:0]    num_q;
  logic [INDEX_W:0]    idx_q;        // next index to issue
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                addr_new_q;   // mem_addr changed at the last edge
  logic                addr_last_q;  // mem_addr holds the final index
  logic                rd_valid_q;   // mem_rdata holds a weight not yet captured
  logic                rd_valid_d;
  logic [INDEX_W-1:0]  rd_idx_q;
  logic                rd_last_q;
  logic                busy_q;
  logic                done_q;

  beat_t               push_beat_s;
  beat_t               head_beat_s;
  logic [BEAT_W-1:0]   head_raw_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                pop_s;
  logic                push_s;
  logic                credit_ok_s;
  logic                issue_last_s;

  weight_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (push_beat_s),
    .pop_i       (pop_s),
    .head_o      (head_raw_s),
    .count_o     (fifo_count_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s)
  );

  // Handshake, capture and issue-credit decisions for this cycle.
  // A landed weight that finds the buffer full stays pending: the credit
  // rule guarantees no new address was issued meanwhile, so mem_addr is held
  // and the memory keeps returning that same weight until there is room.
  always_comb begin
    head_beat_s        = beat_t'(head_raw_s);
    pop_s              = ~fifo_empty_s & out_ready;
    push_s             = rd_valid_q & (~fifo_full_s | pop_s);
    rd_valid_d         = addr_new_q | (rd_valid_q & ~push_s);
    credit_ok_s        = (int'(fifo_count_s) + int'(rd_valid_q)) < (FIFO_DEPTH + int'(pop_s));
    issue_last_s       = (idx_q == (num_q - CNT_ONE));
    push_beat_s.weight = mem_rdata;
    push_beat_s.index  = rd_idx_q;
    push_beat_s.last   = rd_last_q;
  end

  assign mem_addr   = mem_addr_q;
  assign out_valid  = ~fifo_empty_s;
  assign out_weight = head_beat_s.weight;
  assign out_index  = head_beat_s.index;
  assign out_last   = head_beat_s.last;
  assign busy       = busy_q;
  assign done       = done_q;

  // Sequencer FSM with address issue and read-latency tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      neuron_q    <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      addr_new_q  <= 1'b0;
      addr_last_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      addr_new_q <= 1'b0;
      rd_valid_q <= rd_valid_d;
      if (addr_new_q) begin
        rd_idx_q  <= mem_addr_q[INDEX_W-1:0];
        rd_last_q <= addr_last_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_inputs != '0) begin
              // Index 0 goes out on the start edge so the first address is
              // presented in the very next cycle.
              layer_q     <= layer;
              neuron_q    <= neuron;
              num_q       <= num_inputs;
              idx_q       <= CNT_ONE;
              mem_addr_q  <= make_addr(layer, neuron, '0);
              addr_new_q  <= 1'b1;
              addr_last_q <= (num_inputs == CNT_ONE);
              busy_q      <= 1'b1;
              state_q     <= (num_inputs == CNT_ONE) ? ST_DRAIN : ST_ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (credit_ok_s) begin
            mem_addr_q  <= make_addr(layer_q, neuron_q, idx_q[INDEX_W-1:0]);
            addr_new_q  <= 1'b1;
            addr_last_q <= issue_last_s;
            idx_q       <= idx_q + CNT_ONE;
            if (issue_last_s) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The final beat is the only entry left once it is at the head
          if (pop_s && head_beat_s.last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch.sv
// Scoreboard bench for weight_fetch: directed requests push expected beats,
// an independent negedge monitor pops and compares accepted beats.
module tb_weight_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  layer;
  logic [3:0]  neuron;
  logic [10:0] num_inputs;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_weight;
  logic [9:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  weight_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .layer      (layer),
    .neuron     (neuron),
    .num_inputs (num_inputs),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_weight (out_weight),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Weight memory with one-cycle registered read
  logic [7:0] mem [65536];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int w;
    int idx;
    int last;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   s0           = 0;
  int   exp_done_cyc = -1;
  int   done_cnt     = 0;
  bit   busy_seen    = 1'b0;
  bit   mon_en       = 1'b0;

  task automatic push_exp(input int w, input int idx, input int last, input int c);
    exp_t e;
    e.w = w; e.idx = idx; e.last = last; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: compare accepted beats, hold stability under stall, done timing
  initial begin
    exp_t       e;
    bit         hold_v = 1'b0;
    logic [7:0] hold_w = '0;
    logic [9:0] hold_i = '0;
    logic       hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && reset) begin
        if (hold_v) begin
          check("hold_valid",  int'(out_valid), 1);
          check("hold_weight", int'($signed(out_weight)), int'($signed(hold_w)));
          check("hold_index",  int'(out_index), int'(hold_i));
          check("hold_last",   int'(out_last), int'(hold_l));
        end
        hold_v = out_valid && !out_ready;
        hold_w = out_weight;
        hold_i = out_index;
        hold_l = out_last;
        if (busy) busy_seen = 1'b1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat_index", int'(out_index), -1);
          end else begin
            e = exp_q.pop_front();
            check("beat_weight", int'($signed(out_weight)), e.w);
            check("beat_index",  int'(out_index), e.idx);
            check("beat_last",   int'(out_last), e.last);
            if (e.cyc >= 0) check("beat_cycle", cyc - s0, e.cyc);
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_done_cyc >= 0) check("done_cycle", cyc - s0, exp_done_cyc);
          else check("unexpected_done_cycle", cyc - s0, -1);
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"},   int'(mem_addr), 0);
    check({tag, "_out_valid"},  int'(out_valid), 0);
    check({tag, "_out_weight"}, int'(out_weight), 0);
    check({tag, "_out_index"},  int'(out_index), 0);
    check({tag, "_out_last"},   int'(out_last), 0);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_done"},       int'(done), 0);
  endtask

  // One request: cycle k=0 carries start; stall window, extra start and reset
  // cycle are given relative to it (negative disables them).
  task automatic run(input int ly, input int nr, input int num,
                     input int stall_lo, input int stall_hi,
                     input int restart_k, input int rst_k,
                     input bit addr_chk, input int n_cyc, input int exp_dones);
    int d0;
    int base;
    base = (ly << 14) | (nr << 10);
    d0 = done_cnt;
    busy_seen = 1'b0;
    @(posedge clk); #1;
    s0 = cyc;
    layer      = ly[1:0];
    neuron     = nr[3:0];
    num_inputs = num[10:0];
    for (int k = 0; k < n_cyc; k++) begin
      start     = (k == 0) || (k == restart_k);
      out_ready = !(k >= stall_lo && k <= stall_hi);
      reset     = (k != rst_k);
      @(negedge clk);
      if (addr_chk && k >= 1 && k <= num) check("mem_addr", int'(mem_addr), base + k - 1);
      if (rst_k >= 0 && k == rst_k + 1) check_reset_outputs("abort");
      @(posedge clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    check("beats_left", exp_q.size(), 0);
    exp_q.delete();
    check("done_count", done_cnt - d0, exp_dones);
  endtask

  task automatic push_case1(input int c0, input int c1, input int c2, input int c3);
    push_exp(-3, 0, 0, c0);
    push_exp(14, 1, 0, c1);
    push_exp(3,  2, 0, c2);
    push_exp(-8, 3, 1, c3);
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    layer = '0; neuron = '0; num_inputs = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hFD;  // -3
    mem[16'h0001] = 8'h0E;  // 14
    mem[16'h0002] = 8'h03;  // 3
    mem[16'h0003] = 8'hF8;  // -8
    mem[16'h4400] = 8'h06;
    mem[16'h4401] = 8'h02;
    mem[16'h8000] = 8'h03;
    mem[16'h8001] = 8'h02;
    for (int i = 0; i < 1024; i++) mem[64512 + i] = 8'(i * 7 + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Basic four-weight neuron, full throughput
    push_case1(3, 4, 5, 6);
    exp_done_cyc = 7;
    run(0, 0, 4, -1, -2, -1, -1, 1'b1, 12, 1);

    // Layer 1, neuron 1
    push_exp(6, 0, 0, 3);
    push_exp(2, 1, 1, 4);
    exp_done_cyc = 5;
    run(1, 1, 2, -1, -2, -1, -1, 1'b1, 10, 1);

    // Backpressure in cycles 4-7
    push_case1(3, 8, 9, 10);
    exp_done_cyc = 11;
    run(0, 0, 4, 4, 7, -1, -1, 1'b1, 16, 1);

    // Zero fan-in
    exp_done_cyc = 1;
    run(0, 0, 0, -1, -2, -1, -1, 1'b0, 6, 1);
    check("zero_busy_seen", int'(busy_seen), 0);

    // Start pulsed again while busy
    push_case1(3, 4, 5, 6);
    exp_done_cyc = 7;
    run(0, 0, 4, -1, -2, 2, -1, 1'b1, 14, 1);

    // Reset in cycle 4 aborts; then a fresh request
    push_exp(-3, 0, 0, 3);
    exp_done_cyc = -1;
    run(0, 0, 4, -1, -2, -1, 4, 1'b1, 10, 0);
    push_exp(3, 0, 0, 3);
    push_exp(2, 1, 1, 4);
    exp_done_cyc = 5;
    run(2, 0, 2, -1, -2, -1, -1, 1'b1, 10, 1);

    // Maximum fan-in in the top neuron of the top layer
    for (int i = 0; i < 1024; i++) begin
      v = 8'(i * 7 + 1);
      push_exp(int'($signed(v)), i, (i == 1023) ? 1 : 0, 3 + i);
    end
    exp_done_cyc = 1027;
    run(3, 15, 1024, -1, -2, -1, -1, 1'b1, 1034, 1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_fetch.md
Name: weight_fetch

Overview:
- Read-side sequencer for the weight memory.
- On `start`, it generates the `{layer, neuron, index}` addresses for one neuron's fan-in.
- It absorbs the memory's 1-cycle registered read latency and streams the signed weights to the MAC datapath over a valid/ready interface with backpressure.
- It sits between the layer controller, which issues `start`, and the neuron MAC, which consumes weights.

Parameters:
- ADDR_W, 16, weight memory address width
- DATA_W, 8, signed weight width
- LAYER_W, 2, layer field, `addr[15:14]`
- NEURON_W, 4, neuron field, `addr[13:10]`
- INDEX_W, 10, input-index field, `addr[9:0]`
- FIFO_DEPTH, 2, output skid buffer entries; minimum 2

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; reset==0 at a clk edge resets all state
- start  in  1  one-cycle request; sampled only in IDLE
- layer  in  LAYER_W  layer number, captured on start
- neuron  in  NEURON_W  neuron number, captured on start
- num_inputs  in  INDEX_W+1  fan-in count, 0..1024, captured on start
- mem_addr  out  ADDR_W  registered address to the weight memory
- mem_rdata  in  DATA_W  signed weight; valid the cycle after mem_addr is presented
- out_valid  out  1  out_weight holds a weight
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_weight  out  DATA_W  signed weight
- out_index  out  INDEX_W  input index of out_weight
- out_last  out  1  marks the final weight of the neuron
- busy  out  1  high in ISSUE or DRAIN
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset values:
  - mem_addr=0, out_valid=0, out_weight=0, out_index=0, out_last=0, busy=0, done=0.
  - FIFO empty, in-flight flag cleared, state=IDLE.
  - Reset mid-operation aborts immediately; no further beats or done.
- Address format: `mem_addr = {layer_q, neuron_q, idx}`, with idx counting 0..num_inputs-1.
- States:
  - IDLE:
    - start=1 with num_inputs>0: capture fields, idx=0, go to ISSUE.
    - start=1 with num_inputs=0: pulse done next cycle, stay IDLE, emit no beats.
  - ISSUE:
    - Present one new address per cycle when credit allows: `fifo_count + inflight - pop < FIFO_DEPTH`, where pop = out_valid && out_ready this cycle.
    - When the last index is issued, go to DRAIN.
    - When stalled, mem_addr holds its value; re-reads are harmless but are not captured.
  - DRAIN: wait until FIFO is empty, the in-flight read has landed, and the last beat is accepted; then done=1 for one cycle and return to IDLE.
- In-flight tracking:
  - A 1-bit flag is set in the cycle after a new address is issued.
  - mem_rdata is pushed into the FIFO with its index on that cycle only.
  - Each index is captured exactly once.
- Latency:
  - start high in cycle 0 → mem_addr valid in cycle 1 → mem_rdata in cycle 2 → out_valid in cycle 3.
  - With out_ready held high, throughput is 1 weight/cycle.
  - The last beat appears in cycle num_inputs+2; done is in the following cycle.
- Handshake:
  - Once out_valid rises, out_weight, out_index and out_last are stable until accepted.
  - out_valid does not depend combinationally on out_ready.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged.
  - start while busy is ignored; it is not queued.
- Boundary cases:
  - num_inputs=1024 issues idx 0..1023.
  - idx never wraps into the neuron field.
- Arithmetic: weights are passed through unmodified as signed values; no sign extension.

Decomposition:
- Shared package `mlp_pkg`:
  - LAYER_W, NEURON_W, INDEX_W, ADDR_W, DATA_W.
  - Address field offsets: layer at 14, neuron at 10.
  - State encoding: IDLE, ISSUE, DRAIN.
- One sub-module `weight_skid_fifo`:
  - Parameterised by depth and width (DATA_W + INDEX_W + 1).
  - Provides count, push, pop, empty/full.
  - Same clk and active-low synchronous reset.

Test Plan:
- Memory model uses 1-cycle latency, preloaded as 0x0000..0x0003 = -3, 14, 3, -8.
  - Stimulus: layer=0, neuron=0, num_inputs=4, out_ready=1.
  - Required: mem_addr 0x0000..0x0003 in cycles 1-4; beats -3, 14, 3, -8 in cycles 3-6; out_last in cycle 6; done in cycle 7.
- Memory preloaded as 0x4400=6, 0x4401=2.
  - Stimulus: layer=1, neuron=1, num_inputs=2.
  - Required: mem_addr 0x4400, 0x4401; beats 6, 2 with indices 0, 1; out_last on 2.
- Backpressure:
  - Stimulus: the first case with out_ready=0 in cycles 4-7.
  - Required: output holds 14 stable; no more than FIFO_DEPTH entries plus 1 in flight; sequence still -3, 14, 3, -8 exactly once each.
- Zero fan-in:
  - Stimulus: num_inputs=0.
  - Required: no out_valid; done in cycle 1; busy stays 0.
- Start while busy:
  - Stimulus: start pulsed again in cycle 2 during the first case.
  - Required: ignored; exactly 4 beats and one done.
- Reset mid-operation:
  - Stimulus: reset=0 in cycle 4 of the first case, then a new request layer=2, neuron=0, num_inputs=2 (memory 0x8000=3, 0x8001=2).
  - Required: all outputs at reset values next cycle; no done for the aborted request; new run emits 3, 2 from 0x8000, 0x8001.
